// File: rtl/poly_mul_pkg.sv
// Shared constants, FSM state type and lane-slice helpers for the negacyclic multiplier.
// Build option: POLY_MUL_PRECOMP_EN selects the precomputed-multiple lane datapath.
package poly_mul_pkg;

    localparam int N_COEFF_DEF = 256;
    localparam int Q_W_DEF     = 13;
    localparam int S_W_DEF     = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    function automatic int acc_lsb(input int lane, input int q_w);
        return lane * q_w;
    endfunction

    function automatic int sec_lsb(input int lane, input int s_w);
        return lane * s_w;
    endfunction

    function automatic int prev_lane(input int lane, input int n);
        return (lane == 0) ? n - 1 : lane - 1;
    endfunction

    function automatic int next_lane(input int lane, input int n);
        return (lane == n - 1) ? 0 : lane + 1;
    endfunction

endpackage

// File: rtl/poly_mul_if.sv
// Control, coefficient-stream and result bundle between the datapath and poly_mul_engine.
// Build option: POLY_MUL_PRECOMP_EN (no effect on this interface).
interface poly_mul_if #(
    parameter int N_COEFF = 256,
    parameter int Q_W     = 13,
    parameter int S_W     = 4
) ();
    logic                     start;
    logic                     op_sub;
    logic                     acc_clr;
    logic [N_COEFF*Q_W-1:0]   acc_in;
    logic [N_COEFF*S_W-1:0]   secret_in;
    logic                     a_valid;
    logic [Q_W-1:0]           a_data;
    logic                     a_ready;
    logic                     busy;
    logic                     done;
    logic [N_COEFF*Q_W-1:0]   result;

    modport master (
        output start, op_sub, acc_clr, acc_in, secret_in, a_valid, a_data,
        input  a_ready, busy, done, result
    );

    modport slave (
        input  start, op_sub, acc_clr, acc_in, secret_in, a_valid, a_data,
        output a_ready, busy, done, result
    );
endinterface

// File: rtl/poly_mac_lane.sv
// One accumulator lane: holds acc, rotated secret and negate flag, applies acc +/- a*srot.
// Build option: POLY_MUL_PRECOMP_EN selects a multiple from a shared a*k table instead of multiplying.
module poly_mac_lane #(
    parameter int Q_W = 13,
    parameter int S_W = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           load,
    input  logic [Q_W-1:0]                 acc_init,
    input  logic [S_W-1:0]                 s_init,
    input  logic                           shift,
    input  logic [S_W-1:0]                 srot_in,
    input  logic                           neg_in,
    output logic [S_W-1:0]                 srot_out,
    output logic                           neg_out,
    input  logic                           op_sub,
    input  logic                           upd,
`ifdef POLY_MUL_PRECOMP_EN
    input  logic [S_W-1:0]                 sel_srot,
    input  logic                           sel_neg,
    input  logic [(1<<(S_W-1))*Q_W-1:0]    mult_tab,
`else
    input  logic [Q_W-1:0]                 a_data,
`endif
    output logic [Q_W-1:0]                 acc_out
);

    logic [Q_W-1:0] acc_reg;
    logic [Q_W-1:0] acc_next;
    logic [Q_W-1:0] prod;
    logic [S_W-1:0] srot_reg;
    logic           neg_reg;
    logic           sub_eff;

`ifdef POLY_MUL_PRECOMP_EN
    localparam int MULT_N = 1 << (S_W - 1);
    logic [S_W-1:0] mag;

    // The update lags rotation by one edge, so the secret that belonged to
    // this lane at acceptance now sits in the next lane (sel_srot/sel_neg).
    always_comb begin
        mag     = sel_srot[S_W-1] ? (-sel_srot) : sel_srot;
        prod    = '0;
        for (int k = 1; k <= MULT_N; k++) begin
            if (int'(mag) == k) prod = mult_tab[(k-1)*Q_W +: Q_W];
        end
        sub_eff = op_sub ^ sel_neg ^ sel_srot[S_W-1];
    end
`else
    logic [Q_W-1:0] s_ext;

    always_comb begin
        s_ext   = {{(Q_W-S_W){srot_reg[S_W-1]}}, srot_reg};
        prod    = a_data * s_ext;
        sub_eff = op_sub ^ neg_reg;
    end
`endif

    always_comb begin
        acc_next = sub_eff ? (acc_reg - prod) : (acc_reg + prod);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_reg  <= '0;
            srot_reg <= '0;
            neg_reg  <= 1'b0;
        end else if (load) begin
            acc_reg  <= acc_init;
            srot_reg <= s_init;
            neg_reg  <= 1'b0;
        end else begin
            if (upd) acc_reg <= acc_next;
            if (shift) begin
                srot_reg <= srot_in;
                neg_reg  <= neg_in;
            end
        end
    end

    assign srot_out = srot_reg;
    assign neg_out  = neg_reg;
    assign acc_out  = acc_reg;

endmodule

// File: rtl/poly_mul_engine.sv
// Sequential schoolbook negacyclic multiplier: result = acc +/- a(x)*s(x) mod (x^N+1), one a_j per handshake.
// Build option: POLY_MUL_PRECOMP_EN registers a*k multiples and adds a DRAIN state.
module poly_mul_engine
    import poly_mul_pkg::*;
#(
    parameter int N_COEFF = N_COEFF_DEF,
    parameter int Q_W     = Q_W_DEF,
    parameter int S_W     = S_W_DEF
) (
    input  logic      clk,
    input  logic      rst_n,
    poly_mul_if.slave bus
);

    localparam int CNT_W = $clog2(N_COEFF) + 1;

    state_t               state_reg;
    state_t               state_next;
    logic [CNT_W-1:0]     cnt_reg;
    logic                 op_sub_reg;
    logic                 load;
    logic                 accept;
    logic                 last_acc;
    logic                 lane_upd;
    logic                 a_ready_c;
    logic                 busy_c;
    logic                 done_c;

    logic [S_W-1:0]       srot_w [N_COEFF];
    logic                 neg_w  [N_COEFF];
    logic [Q_W-1:0]       acc_w  [N_COEFF];
    logic [N_COEFF*Q_W-1:0] result_w;

    assign load     = (state_reg == IDLE) && bus.start;
    assign accept   = bus.a_valid && a_ready_c;
    assign last_acc = accept && (cnt_reg == CNT_W'(N_COEFF - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_reg <= IDLE;
        else        state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (bus.start) state_next = RUN;
`ifdef POLY_MUL_PRECOMP_EN
            RUN:     if (last_acc) state_next = DRAIN;
`else
            RUN:     if (last_acc) state_next = DONE;
`endif
            DRAIN:   state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        a_ready_c = (state_reg == RUN) && (cnt_reg < CNT_W'(N_COEFF));
        busy_c    = (state_reg == RUN) || (state_reg == DRAIN);
        done_c    = (state_reg == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg    <= '0;
            op_sub_reg <= 1'b0;
        end else if (load) begin
            cnt_reg    <= '0;
            op_sub_reg <= bus.op_sub;
        end else if (accept) begin
            cnt_reg    <= cnt_reg + 1'b1;
        end
    end

`ifdef POLY_MUL_PRECOMP_EN
    localparam int MULT_N = 1 << (S_W - 1);
    logic                      pend_reg;
    logic [Q_W-1:0]            mult_reg [MULT_N];
    logic [MULT_N*Q_W-1:0]     mult_tab;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pend_reg <= 1'b0;
        else        pend_reg <= accept;
    end

    // mult_reg[k-1] = a_j * k, shared by every lane on the following edge
    for (genvar gi = 0; gi < MULT_N; gi++) begin : g_mult
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)      mult_reg[gi] <= '0;
            else if (accept) mult_reg[gi] <= bus.a_data * Q_W'(gi + 1);
        end
        assign mult_tab[gi*Q_W +: Q_W] = mult_reg[gi];
    end

    assign lane_upd = pend_reg;
`else
    assign lane_upd = accept;
`endif

    for (genvar gi = 0; gi < N_COEFF; gi++) begin : g_lane
        localparam int PL = prev_lane(gi, N_COEFF);
        localparam int NL = next_lane(gi, N_COEFF);
        logic           neg_in_w;
        logic [Q_W-1:0] acc_init_w;

        // Lane 0 receives the wrapped coefficient: x^N = -1 toggles its sign.
        assign neg_in_w   = (gi == 0) ? ~neg_w[PL] : neg_w[PL];
        assign acc_init_w = bus.acc_clr ? '0 : bus.acc_in[acc_lsb(gi, Q_W) +: Q_W];

`ifdef POLY_MUL_PRECOMP_EN
        logic sel_neg_w;
        assign sel_neg_w = (gi == N_COEFF - 1) ? ~neg_w[NL] : neg_w[NL];
`endif

        poly_mac_lane #(
            .Q_W (Q_W),
            .S_W (S_W)
        ) u_lane (
            .clk      (clk),
            .rst_n    (rst_n),
            .load     (load),
            .acc_init (acc_init_w),
            .s_init   (bus.secret_in[sec_lsb(gi, S_W) +: S_W]),
            .shift    (accept),
            .srot_in  (srot_w[PL]),
            .neg_in   (neg_in_w),
            .srot_out (srot_w[gi]),
            .neg_out  (neg_w[gi]),
            .op_sub   (op_sub_reg),
            .upd      (lane_upd),
`ifdef POLY_MUL_PRECOMP_EN
            .sel_srot (srot_w[NL]),
            .sel_neg  (sel_neg_w),
            .mult_tab (mult_tab),
`else
            .a_data   (bus.a_data),
`endif
            .acc_out  (acc_w[gi])
        );

        assign result_w[acc_lsb(gi, Q_W) +: Q_W] = acc_w[gi];
    end

    assign bus.a_ready = a_ready_c;
    assign bus.busy    = busy_c;
    assign bus.done    = done_c;
    assign bus.result  = result_w;

endmodule

// File: tb/tb_poly_mul_engine.sv
// Randomized bench for poly_mul_engine against a direct negacyclic convolution model.
// Build option: POLY_MUL_PRECOMP_EN adds one cycle to the expected latency.
module tb_poly_mul_engine;
    import poly_mul_pkg::*;

    localparam int N  = N_COEFF_DEF;
    localparam int QW = Q_W_DEF;
    localparam int SW = S_W_DEF;
`ifdef POLY_MUL_PRECOMP_EN
    localparam int PRE = 1;
`else
    localparam int PRE = 0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    poly_mul_if #(.N_COEFF(N), .Q_W(QW), .S_W(SW)) bus ();

    poly_mul_engine #(.N_COEFF(N), .Q_W(QW), .S_W(SW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;
    int acc_m [N];
    int s_m   [N];
    int a_m   [N];
    int exp_m [N];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        if (obs !== expv) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, expv);
        end
    endtask

    function automatic int lane(input int i);
        return int'(bus.result[i*QW +: QW]);
    endfunction

    // exp = (clr ? 0 : acc) +/- a*s in Z[x]/(x^N+1), coefficients mod 2^QW
    function automatic void model_calc(input bit op, input bit clr);
        longint sum [N];
        longint v;
        for (int k = 0; k < N; k++) sum[k] = 0;
        for (int i = 0; i < N; i++) begin
            if (a_m[i] == 0) continue;
            for (int j = 0; j < N; j++) begin
                if (i + j < N) sum[i+j]     += longint'(a_m[i]) * s_m[j];
                else           sum[i+j-N]   -= longint'(a_m[i]) * s_m[j];
            end
        end
        for (int k = 0; k < N; k++) begin
            v = (clr ? 0 : longint'(acc_m[k])) + (op ? -sum[k] : sum[k]);
            exp_m[k] = int'(v & ((64'd1 << QW) - 1));
        end
    endfunction

    task automatic clear_vecs();
        for (int i = 0; i < N; i++) begin
            acc_m[i] = 0; s_m[i] = 0; a_m[i] = 0;
        end
    endtask

    task automatic rand_vecs();
        for (int i = 0; i < N; i++) begin
            acc_m[i] = int'($urandom_range(0, (1 << QW) - 1));
            s_m[i]   = int'($urandom_range(0, (1 << SW) - 1)) - (1 << (SW - 1));
            a_m[i]   = int'($urandom_range(0, (1 << QW) - 1));
        end
    endtask

    task automatic run_op(input bit op, input bit clr, input bit stall,
                          input bit mid_start, input int rst_at);
        int j = 0;
        int cyc;
        bit seen = 1'b0;
        bit tgl = 1'b1;
        int lat;
        model_calc(op, clr);
        @(negedge clk);
        bus.op_sub  = op;
        bus.acc_clr = clr;
        for (int i = 0; i < N; i++) begin
            bus.acc_in[i*QW +: QW]    = QW'(acc_m[i]);
            bus.secret_in[i*SW +: SW] = SW'(s_m[i]);
        end
        bus.start   = 1'b1;
        bus.a_valid = 1'b1;           // must not be consumed while IDLE
        bus.a_data  = QW'(12'habc);
        @(negedge clk);
        bus.start   = 1'b0;
        bus.a_valid = 1'b0;
        cyc = 1;
        while (cyc < 4 * N) begin
            if (rst_at == cyc) begin
                rst_n = 1'b0;
                bus.a_valid = 1'b0;
                @(negedge clk);
                check("rst_result_zero", (bus.result == '0), 1);
                check("rst_a_ready", bus.a_ready, 0);
                check("rst_busy", bus.busy, 0);
                check("rst_done", bus.done, 0);
                rst_n = 1'b1;
                return;
            end
            if (bus.done) begin
                seen = 1'b1;
                break;
            end
            if (cyc == 1) check("busy_rise", bus.busy, 1);
            bus.start = mid_start && (cyc == 5);
            if (j < N && (!stall || tgl)) begin
                bus.a_valid = 1'b1;
                bus.a_data  = QW'(a_m[j]);
            end else begin
                bus.a_valid = 1'b0;
                bus.a_data  = QW'($urandom);
            end
            if (bus.a_valid && bus.a_ready) j++;
            tgl = ~tgl;
            @(negedge clk);
            cyc++;
        end
        bus.start   = 1'b0;
        bus.a_valid = 1'b0;
        if (!seen) begin
            check("done_timeout", 0, 1);
            return;
        end
        lat = (stall ? 2 * N : N + 1) + PRE;
        check("latency", cyc, lat);
        check("busy_at_done", bus.busy, 0);
        check("a_ready_at_done", bus.a_ready, 0);
        for (int i = 0; i < N; i++)
            check($sformatf("lane%0d", i), lane(i), exp_m[i]);
        @(negedge clk);
        check("done_one_cycle", bus.done, 0);
        @(negedge clk);
        check("hold_lane0", lane(0), exp_m[0]);
        check("hold_laneN1", lane(N - 1), exp_m[N - 1]);
    endtask

    initial begin
        bus.start = 1'b0; bus.op_sub = 1'b0; bus.acc_clr = 1'b0;
        bus.acc_in = '0; bus.secret_in = '0; bus.a_valid = 1'b0; bus.a_data = '0;
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_result_zero", (bus.result == '0), 1);
        check("reset_a_ready", bus.a_ready, 0);
        check("reset_busy", bus.busy, 0);
        check("reset_done", bus.done, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // identity: a = 1
        clear_vecs();
        s_m[0] = 3; s_m[N-1] = -2; a_m[0] = 1;
        run_op(1'b0, 1'b1, 1'b0, 1'b0, -1);
        check("id_r0", lane(0), 3);
        check("id_rN1", lane(N - 1), 8190);

        // negacyclic wrap: a = x
        a_m[0] = 0; a_m[1] = 1;
        run_op(1'b0, 1'b1, 1'b0, 1'b0, -1);
        check("wrap_r0", lane(0), 2);
        check("wrap_r1", lane(1), 3);

        // subtract onto an initial accumulator, including s = -2^(SW-1)
        clear_vecs();
        for (int i = 0; i < N; i++) acc_m[i] = 100;
        s_m[0] = -4; a_m[0] = 5;
        run_op(1'b1, 1'b0, 1'b0, 1'b0, -1);
        check("sub_r0", lane(0), 120);
        check("sub_r1", lane(1), 100);
        s_m[0] = -8;
        run_op(1'b1, 1'b0, 1'b0, 1'b0, -1);
        check("sub_min_r0", lane(0), 140);

        // random operands: back-to-back, then the same data with a stalling stream
        for (int t = 0; t < 2; t++) begin
            bit op, clr;
            rand_vecs();
            op  = 1'($urandom);
            clr = (t == 1);
            run_op(op, clr, 1'b0, 1'b0, -1);
            run_op(op, clr, 1'b1, 1'b0, -1);
        end

        // start pulsed while busy is ignored
        rand_vecs();
        run_op(1'b1, 1'b0, 1'b0, 1'b1, -1);

        // reset mid-RUN aborts, next operation behaves normally
        rand_vecs();
        run_op(1'b0, 1'b0, 1'b0, 1'b0, 40);
        rand_vecs();
        run_op(1'b0, 1'b0, 1'b1, 1'b0, -1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
